// File: rtl/io_debounce.sv
// io_debounce -- input conditioning for board buttons and slide switches.
//
// Each raw pin is brought into clk through a 2-flop synchroniser. It is then
// debounced by a per-bit stability counter. One shared prescaler tick paces
// all of the per-bit counters. The block outputs clean levels. For buttons it
// also outputs 1-cycle press/release pulses.
//
// Build option: IO_DEBOUNCE_BYPASS_EN
//   defined     - no prescaler and no counters; each clean level is the
//                 synchronised pin registered once (3 cycles raw->out).
//                 Intended for fast simulation of downstream software.
//   not defined - full debounce (default).
//
// Parameters:
//   N_BTN     number of push buttons
//   N_SW      number of slide switches
//   TICK_DIV  clk cycles per debounce tick (>=2)
//   DB_TICKS  consecutive ticks a changed input must hold (>=1)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   btn_raw        asynchronous raw button pins
//   sw_raw         asynchronous raw switch pins
//   btn_db         debounced button levels
//   sw_db          debounced switch levels
//   btn_press      1-cycle pulse per bit, the cycle after btn_db rises
//   btn_release    1-cycle pulse per bit, the cycle after btn_db falls
//   btn_any_press  OR of btn_press, same cycle

`ifndef IO_DEBOUNCE_BYPASS_EN
// Stability filter for one bit. The output level follows the synchronised
// input only after the input has differed from it across DB_TICKS
// consecutive ticks. Any return to the current level clears the progress.
module io_debounce_bit #(
    parameter int DB_TICKS = 1000,
    parameter int CW       = $clog2(DB_TICKS + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sync,
    output logic level
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync == level) begin
            // Glitch back to the current level restarts the filter.
            cnt <= '0;
        end else if (tick) begin
            if (cnt == CW'(DB_TICKS - 1)) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
`endif

module io_debounce #(
    parameter int N_BTN    = 5,
    parameter int N_SW     = 16,
    parameter int TICK_DIV = 1000,
    parameter int DB_TICKS = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_SW-1:0]  sw_db,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             btn_any_press
);
    localparam int NB = N_BTN + N_SW;

    // Buttons occupy the low bits, switches the high bits.
    logic [NB-1:0] s1, s2, db_all;
    logic [N_BTN-1:0] btn_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {sw_raw, btn_raw};
            s2 <= s1;
        end
    end

`ifdef IO_DEBOUNCE_BYPASS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) db_all <= '0;
        else        db_all <= s2;
    end
`else
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = (pcnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)    pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 1'b1;
    end

    for (genvar i = 0; i < NB; i++) begin : g_bit
        io_debounce_bit #(.DB_TICKS(DB_TICKS)) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .sync  (s2[i]),
            .level (db_all[i])
        );
    end
`endif

    assign btn_db = db_all[N_BTN-1:0];
    assign sw_db  = db_all[N_BTN +: N_SW];

    // Edge detection compares the clean level with its value one cycle
    // earlier. Pulses therefore trail the level change by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev      <= '0;
            btn_press     <= '0;
            btn_release   <= '0;
            btn_any_press <= 1'b0;
        end else begin
            btn_prev      <= btn_db;
            btn_press     <= btn_db & ~btn_prev;
            btn_release   <= ~btn_db & btn_prev;
            btn_any_press <= |(btn_db & ~btn_prev);
        end
    end
endmodule

// File: tb/tb_io_debounce.sv
// Testbench for io_debounce, built with TICK_DIV=4 and DB_TICKS=3.
// Filter time after the synchronised input changes is 9..12 cycles.
// After reset, the prescaler phase is known, so those sequences check exact cycles.
module tb_io_debounce;
    localparam int N_BTN = 5;
    localparam int N_SW  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_db, btn_press, btn_release;
    logic [N_SW-1:0]  sw_db;
    logic             btn_any_press;

    io_debounce #(.N_BTN(N_BTN), .N_SW(N_SW), .TICK_DIV(4), .DB_TICKS(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .sw_raw        (sw_raw),
        .btn_db        (btn_db),
        .sw_db         (sw_db),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .btn_any_press (btn_any_press)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1 ns after.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [N_BTN-1:0] btn;
        logic [N_SW-1:0]  sw;
        int               hold;
        logic [N_BTN-1:0] e_btn;
        logic [N_SW-1:0]  e_sw;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n;
        int bad;
        bit found;
        logic [N_SW-1:0] prev_sw;

        // Steady-state vectors. A hold of 20 always settles; a hold of at most
        // 10 never does, because the filter plus synchroniser needs at least 11 edges.
        tbl[0] = '{5'h00, 16'h0000, 20, 5'h00, 16'h0000};
        tbl[1] = '{5'h01, 16'h0001, 20, 5'h01, 16'h0001};
        tbl[2] = '{5'h1F, 16'hFFFF,  6, 5'h01, 16'h0001};
        tbl[3] = '{5'h01, 16'h0001, 20, 5'h01, 16'h0001};
        tbl[4] = '{5'h0A, 16'h1234, 20, 5'h0A, 16'h1234};
        tbl[5] = '{5'h15, 16'hEDCB, 20, 5'h15, 16'hEDCB};
        tbl[6] = '{5'h00, 16'h0000, 10, 5'h15, 16'hEDCB};
        tbl[7] = '{5'h00, 16'h0000, 10, 5'h00, 16'h0000};

        // Reset with all raw inputs high.
        rst_n   = 1'b0;
        btn_raw = 5'h1F;
        sw_raw  = 16'hFFFF;
        step(3);
        chk("rst btn_db", btn_db, 0);
        chk("rst sw_db", sw_db, 0);
        chk("rst btn_press", btn_press, 0);
        chk("rst btn_release", btn_release, 0);
        chk("rst btn_any_press", btn_any_press, 0);
        btn_raw = '0;
        sw_raw  = '0;
        step(1);
        rst_n = 1'b1;

`ifdef IO_DEBOUNCE_BYPASS_EN
        // Bypass: 3 cycles raw->level, and glitches pass through.
        btn_raw = 5'h02;
        step(2);
        chk("byp db before", btn_db, 5'h00);
        step(1);
        chk("byp db rise", btn_db, 5'h02);
        chk("byp press early", btn_press, 5'h00);
        step(1);
        chk("byp press", btn_press, 5'h02);
        chk("byp any", btn_any_press, 1);
        btn_raw = 5'h00;
        step(1);
        btn_raw = 5'h02;
        step(1);
        chk("byp glitch pre", btn_db, 5'h02);
        step(1);
        chk("byp glitch low", btn_db, 5'h00);
        step(1);
        chk("byp glitch back", btn_db, 5'h02);
        chk("byp release", btn_release, 5'h02);
        step(1);
        chk("byp press2", btn_press, 5'h02);
`else
        // Clean press right after reset. The prescaler ticks on edges 4, 8 and 12,
        // so the level rises on edge 12.
        btn_raw = 5'h01;
        step(11);
        chk("press db edge11", btn_db, 5'h00);
        step(1);
        chk("press db edge12", btn_db, 5'h01);
        chk("press pulse early", btn_press, 5'h00);
        step(1);
        chk("press pulse", btn_press, 5'h01);
        chk("press any", btn_any_press, 1);
        step(1);
        chk("press pulse end", btn_press, 5'h00);
        chk("press any end", btn_any_press, 0);

        // Table-driven steady-state and short-glitch vectors.
        for (int i = 0; i < 8; i++) begin
            btn_raw = tbl[i].btn;
            sw_raw  = tbl[i].sw;
            step(tbl[i].hold);
            chk($sformatf("tbl%0d btn_db", i), btn_db, tbl[i].e_btn);
            chk($sformatf("tbl%0d sw_db", i), sw_db, tbl[i].e_sw);
        end

        // Bounce: toggling every 3 cycles never reaches the filter time.
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_raw[2] = ~btn_raw[2];
            step(1);
            if (btn_db != 5'h00 || btn_press != 5'h00 || btn_any_press) bad++;
        end
        chk("bounce quiet", bad, 0);
        btn_raw[2] = 1'b0;
        step(1);
        btn_raw[2] = 1'b1;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (btn_db[2]) begin
                found = 1'b1;
                n = i;
                break;
            end
        end
        chk("bounce settles", found, 1);
        chk("bounce latency 11..14", (n >= 11 && n <= 14), 1);
        step(1);
        chk("bounce press", btn_press, 5'h04);

        // Release of btn[4] in parallel with a switch change on the same cycle.
        btn_raw = 5'h10;
        sw_raw  = 16'h0000;
        step(20);
        chk("par setup", btn_db, 5'h10);
        btn_raw = 5'h00;
        sw_raw  = 16'hA5A5;
        prev_sw = sw_db;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (btn_db[4] == 1'b0) begin
                found = 1'b1;
                n = i;
                break;
            end
            prev_sw = sw_db;
        end
        chk("par fall seen", found, 1);
        chk("par latency 11..14", (n >= 11 && n <= 14), 1);
        chk("par sw_db same cycle", sw_db, 16'hA5A5);
        chk("par sw_db before", prev_sw, 16'h0000);
        step(1);
        chk("par release", btn_release, 5'h10);
        chk("par no any_press", btn_any_press, 0);
        step(1);
        chk("par release end", btn_release, 5'h00);

        // Reset mid-filter. After 10 edges, two ticks have passed (cnt=2) and the level is unchanged.
        btn_raw = 5'h08;
        step(10);
        chk("mid db before rst", btn_db, 5'h00);
        rst_n = 1'b0;
        step(1);
        chk("mid rst btn_db", btn_db, 5'h00);
        chk("mid rst sw_db", sw_db, 16'h0000);
        chk("mid rst release", btn_release, 5'h00);
        rst_n = 1'b1;
        step(11);
        chk("mid restart edge11 btn", btn_db, 5'h00);
        chk("mid restart edge11 sw", sw_db, 16'h0000);
        step(1);
        chk("mid restart edge12 btn", btn_db, 5'h08);
        chk("mid restart edge12 sw", sw_db, 16'hA5A5);
        step(1);
        chk("mid press", btn_press, 5'h08);
        chk("mid any", btn_any_press, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
